// File: rtl/me_select_commit_pkg.sv
// Shared types for the mutation-loop select/commit block: weight width,
// reset weight value, weight-set type and the control state encoding.
package me_select_commit_pkg;

    localparam int WW = 8;
    localparam logic [WW-1:0] W_INIT_DEF = 8'd100;

    typedef logic [3:0][WW-1:0] wset_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BASE,
        S_MUTATE,
        S_WAIT,
        S_EVAL,
        S_DECIDE,
        S_HALT
    } state_t;

endpackage

// File: rtl/me_select_commit_if.sv
// Bundle between the select/commit block, the mutation engine and the evaluator.
// master drives control/candidates/fitness; slave is the select/commit block.
interface me_select_commit_if #(parameter int FW = 16);
    import me_select_commit_pkg::*;

    logic          start;
    logic          abort;
    wset_t         cand;
    logic          eval_done;
    logic [FW-1:0] fitness;
    wset_t         w;
    wset_t         try_w;
    logic          mut_trig;
    logic          eval_req;
    logic [FW-1:0] best_fit;
    logic [15:0]   iter;
    logic          busy;
    logic          done;
    logic          stall;

    modport master (
        output start, abort, cand, eval_done, fitness,
        input  w, try_w, mut_trig, eval_req, best_fit, iter, busy, done, stall
    );

    modport slave (
        input  start, abort, cand, eval_done, fitness,
        output w, try_w, mut_trig, eval_req, best_fit, iter, busy, done, stall
    );

endinterface

// File: rtl/me_select_commit_eval_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
// Latency: load takes effect on the next edge; counts only while en is high.
module me_eval_timer #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          expire
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/me_select_commit.sv
// Mutation-loop select/commit: triggers mutations, presents candidates for
// evaluation and commits only strict fitness improvements. Waits on evaluator up to EVAL_TO cycles.
module me_select_commit
    import me_select_commit_pkg::*;
#(
    parameter int            FW       = 16,
    parameter int            ITER_MAX = 1024,
    parameter int            STALL_N  = 32,
    parameter int            EVAL_TO  = 4095,
    parameter logic [WW-1:0] W_INIT   = W_INIT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    me_select_commit_if.slave   bus
);

    localparam int CW = $clog2(EVAL_TO + 1);
    localparam int RW = $clog2(STALL_N + 1);

    state_t        state, state_nx;
    wset_t         w, cand_q;
    logic [FW-1:0] best, fit_q;
    logic          fit_ok;
    logic          base_pass;
    logic [15:0]   iter;
    logic [15:0]   iter_inc;
    logic [RW-1:0] rej;
    logic          wait_cnt;
    logic          timer_load;
    logic          expire;
    logic          accept;

    assign iter_inc = iter + 16'd1;
    assign accept   = fit_ok && (fit_q > best);

    // Timer is loaded one cycle before EVAL so expiry lands on its last cycle.
    me_eval_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (CW'(EVAL_TO - 1)),
        .en       (state == S_EVAL),
        .expire   (expire)
    );

    always_comb begin
        state_nx   = state;
        timer_load = 1'b0;
        unique case (state)
            S_IDLE:   if (bus.start) state_nx = S_BASE;
            S_BASE: begin
                state_nx   = S_EVAL;
                timer_load = 1'b1;
            end
            S_MUTATE: state_nx = S_WAIT;
            S_WAIT: begin
                if (wait_cnt) begin
                    state_nx   = S_EVAL;
                    timer_load = 1'b1;
                end
            end
            S_EVAL:   if (bus.eval_done || expire) state_nx = S_DECIDE;
            S_DECIDE: state_nx = (!base_pass && (iter_inc == 16'(ITER_MAX))) ? S_HALT : S_MUTATE;
            S_HALT:   if (bus.start) state_nx = S_BASE;
            default:  state_nx = S_IDLE;
        endcase
        if (bus.abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            w         <= {4{W_INIT}};
            cand_q    <= {4{W_INIT}};
            best      <= '0;
            fit_q     <= '0;
            fit_ok    <= 1'b0;
            base_pass <= 1'b0;
            iter      <= '0;
            rej       <= '0;
            wait_cnt  <= 1'b0;
        end else begin
            state <= state_nx;
            if (!bus.abort) begin
                case (state)
                    S_IDLE, S_HALT: begin
                        if (bus.start) begin
                            iter      <= '0;
                            rej       <= '0;
                            base_pass <= 1'b1;
                        end
                    end
                    S_BASE:   cand_q <= w;
                    S_MUTATE: wait_cnt <= 1'b0;
                    S_WAIT: begin
                        wait_cnt <= ~wait_cnt;
                        if (wait_cnt) cand_q <= bus.cand;
                    end
                    // Last EVAL cycle wins: fit_ok low means the timer ran out.
                    S_EVAL: begin
                        fit_ok <= bus.eval_done;
                        fit_q  <= bus.fitness;
                    end
                    S_DECIDE: begin
                        base_pass <= 1'b0;
                        if (base_pass) begin
                            best <= fit_ok ? fit_q : '0;
                        end else begin
                            iter <= iter_inc;
                            if (accept) begin
                                w    <= cand_q;
                                best <= fit_q;
                                rej  <= '0;
                            end else if (rej != RW'(STALL_N)) begin
                                rej <= rej + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.w        = w;
    assign bus.try_w    = (state == S_EVAL) ? cand_q : w;
    assign bus.mut_trig = (state == S_MUTATE);
    assign bus.eval_req = (state == S_EVAL);
    assign bus.best_fit = best;
    assign bus.iter     = iter;
    assign bus.busy     = (state != S_IDLE) && (state != S_HALT);
    assign bus.done     = (state == S_HALT);
    assign bus.stall    = (rej == RW'(STALL_N));

endmodule

// File: tb/tb_me_select_commit.sv
// Directed + randomized bench for me_select_commit against a behavioural
// model of the accept/reject/stall/iteration rules.
module tb_me_select_commit;

    localparam int FW       = 16;
    localparam int ITER_MAX = 12;
    localparam int STALL_N  = 4;
    localparam int EVAL_TO  = 20;

    logic clk = 1'b0;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] w_m;
    int          best_m;
    int          rej_m;
    int          iter_m;

    me_select_commit_if #(.FW(FW)) bus ();

    me_select_commit #(
        .FW       (FW),
        .ITER_MAX (ITER_MAX),
        .STALL_N  (STALL_N),
        .EVAL_TO  (EVAL_TO),
        .W_INIT   (8'd100)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Answer the current evaluation (or let it time out); returns in DECIDE.
    task automatic eval_answer(input int fit, input bit respond, input int delay);
        int n;
        if (respond) begin
            repeat (delay) tick();
            bus.eval_done = 1'b1;
            bus.fitness   = 16'(fit);
            tick();
            bus.eval_done = 1'b0;
        end else begin
            n = 0;
            while (bus.eval_req && n < EVAL_TO + 10) begin
                n++;
                tick();
            end
            check("eval_timeout_len", n, EVAL_TO);
        end
    endtask

    task automatic check_status(input string pfx);
        check({pfx, "_w"}, bus.w, w_m);
        check({pfx, "_best"}, bus.best_fit, best_m);
        check({pfx, "_iter"}, bus.iter, iter_m);
        check({pfx, "_stall"}, bus.stall, rej_m == STALL_N);
        check({pfx, "_done"}, bus.done, iter_m == ITER_MAX);
        check({pfx, "_busy"}, bus.busy, iter_m != ITER_MAX);
    endtask

    task automatic do_base(input int fit, input bit respond, input int delay);
        bit seen;
        seen = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (bus.eval_req) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("base_entry", seen, 1);
        check("base_try", bus.try_w, w_m);
        eval_answer(fit, respond, delay);
        tick();
        best_m = respond ? fit : 0;
        iter_m = 0;
        rej_m  = 0;
        check_status("base");
        check("base_mut_trig", bus.mut_trig, 1);
    endtask

    task automatic do_iteration(input logic [31:0] c, input int fit, input bit respond,
                                input int delay, input bit stray);
        int  trig;
        bit  seen;
        trig = 0;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (bus.eval_req) begin
                seen = 1'b1;
                break;
            end
            if (bus.mut_trig) begin
                trig++;
                bus.cand = c;
                if (stray) begin
                    bus.eval_done = 1'b1;
                    bus.fitness   = 16'hffff;
                end
            end
            tick();
            bus.eval_done = 1'b0;
        end
        check("mut_trig_count", trig, 1);
        check("eval_entry", seen, 1);
        check("try_cand", bus.try_w, c);
        eval_answer(fit, respond, delay);
        tick();
        iter_m++;
        if (respond && fit > best_m) begin
            w_m    = c;
            best_m = fit;
            rej_m  = 0;
        end else if (rej_m < STALL_N) begin
            rej_m++;
        end
        check_status("iter");
    endtask

    task automatic rand_iter();
        int fit;
        fit = best_m + int'($urandom_range(0, 6)) - 3;
        if (fit < 0) fit = 0;
        do_iteration($urandom, fit, $urandom_range(0, 7) != 0,
                     int'($urandom_range(0, EVAL_TO - 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.cand      = '0;
        bus.eval_done = 1'b0;
        bus.fitness   = '0;
        w_m    = {4{8'd100}};
        best_m = 0;
        rej_m  = 0;
        iter_m = 0;
        repeat (3) tick();

        check("rst_w", bus.w, w_m);
        check("rst_try", bus.try_w, w_m);
        check("rst_best", bus.best_fit, 0);
        check("rst_iter", bus.iter, 0);
        check("rst_mut_trig", bus.mut_trig, 0);
        check("rst_eval_req", bus.eval_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_stall", bus.stall, 0);
        reset_n = 1'b1;
        tick();

        // Seed, first accept, tie, stall build-up, recovery
        do_base(50, 1'b1, 3);
        do_iteration({8'd115, 8'd100, 8'd92, 8'd108}, 60, 1'b1, 2, 1'b0);
        do_iteration($urandom, 60, 1'b1, 0, 1'b1);
        do_iteration($urandom, 30, 1'b1, 5, 1'b0);
        do_iteration($urandom, 10, 1'b1, 1, 1'b0);
        do_iteration($urandom, 59, 1'b1, 7, 1'b0);
        check("stall_after_4", bus.stall, 1);
        do_iteration($urandom, 61, 1'b1, 4, 1'b0);
        check("stall_cleared", bus.stall, 0);

        // Timeout rejects; response on the expiry cycle is used
        do_iteration($urandom, 90, 1'b0, 0, 1'b0);
        do_iteration({8'd1, 8'd2, 8'd3, 8'd4}, 70, 1'b1, EVAL_TO - 1, 1'b0);
        while (iter_m < ITER_MAX) rand_iter();

        repeat (5) tick();
        check("halt_done", bus.done, 1);
        check("halt_busy", bus.busy, 0);
        check("halt_mut_trig", bus.mut_trig, 0);

        // Restart from HALT: BEST_FIT reseeded even when lower
        do_base(5, 1'b1, 0);
        rand_iter();

        // ABORT during WAIT
        bus.cand = $urandom;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_eval_req", bus.eval_req, 0);
        check("abort_w", bus.w, w_m);
        check("abort_best", bus.best_fit, best_m);
        repeat (5) tick();
        check("abort_idle_hold", bus.busy, 0);

        // Base pass timeout seeds BEST_FIT with zero
        do_base(0, 1'b0, 0);
        rand_iter();
        rand_iter();

        // Reset in the middle of EVAL
        for (int n = 0; n < 50 && !bus.eval_req; n++) begin
            if (bus.mut_trig) bus.cand = $urandom;
            tick();
        end
        check("pre_reset_eval_req", bus.eval_req, 1);
        reset_n = 1'b0;
        tick();
        w_m    = {4{8'd100}};
        best_m = 0;
        rej_m  = 0;
        iter_m = 0;
        check("mrst_eval_req", bus.eval_req, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_w", bus.w, w_m);
        check("mrst_try", bus.try_w, w_m);
        check("mrst_best", bus.best_fit, 0);
        check("mrst_iter", bus.iter, 0);
        reset_n = 1'b1;
        bus.eval_done = 1'b1;
        bus.fitness   = 16'd999;
        tick();
        bus.eval_done = 1'b0;
        tick();
        check("late_done_busy", bus.busy, 0);
        check("late_done_best", bus.best_fit, 0);

        // Full randomized run
        do_base(int'($urandom_range(0, 40)), 1'b1, int'($urandom_range(0, EVAL_TO - 1)));
        while (iter_m < ITER_MAX) rand_iter();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
